esn_load_sequencer: RTL and testbench

Front-end controller for the ESN core. It accepts weight/state words from a host over a valid/ready stream and writes them into the five SRAM regions through the core's off-chip load port (`Data_in`, `addr_inSRAM_offchip`, `SEL_SRAM_input`). It then releases the core by holding `EN_system_n` low for a fixed run window and reports completion. It sits between the host interface and the ESN top level, and is the only driver of the core's load and enable pins.

---
 rtl/esn_load_sequencer_if.sv | 12 +
 rtl/esn_load_sequencer.sv | 142 ++++++++++++++
 tb/tb_esn_load_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/esn_load_sequencer_if.sv
// Host-side valid/ready word stream feeding esn_load_sequencer.
// The master (host) drives data/valid; the slave (sequencer) drives ready.
interface esn_load_sequencer_if #(
  parameter int bit_length = 32
);
  logic [bit_length-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/esn_load_sequencer.sv
// Loads host words into the five ESN SRAM regions, then runs the core for a fixed window.
// Optional LOAD_CHECKSUM_EN macro enables the running XOR checksum of accepted words.
module esn_load_sequencer #(
  parameter int bit_length       = 32,
  parameter int addr_length_heap = 10,
  parameter int node_num         = 1000,
  parameter int run_cycles       = 6000
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        start,
  input  logic                        abort,
  esn_load_sequencer_if.slave         host,
  output logic [bit_length-1:0]       Data_in,
  output logic [addr_length_heap-1:0] addr_inSRAM_offchip,
  output logic [2:0]                  SEL_SRAM_input,
  output logic                        EN_system_n,
  output logic                        busy,
  output logic                        done,
  output logic [bit_length-1:0]       checksum
);

  localparam int CNT_W = $clog2(run_cycles + 1);
  localparam logic [addr_length_heap-1:0] ADDR_LAST = addr_length_heap'(node_num - 1);
  localparam logic [2:0] LAST_REGION = 3'd4;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                      state, state_next;
  logic [2:0]                  region, region_next;
  logic [addr_length_heap-1:0] addr, addr_next;
  logic [CNT_W-1:0]            cnt, cnt_next;
  logic [2:0]                  sel_next;
  logic                        en_n_next;
  logic                        done_next;
  logic                        beat;

  always_comb begin
    state_next   = state;
    region_next  = region;
    addr_next    = addr;
    cnt_next     = cnt;
    sel_next     = '0;
    en_n_next    = 1'b1;
    done_next    = 1'b0;
    host.s_ready = (state == LOAD) && !abort;
    beat         = host.s_valid && host.s_ready;

    if (abort) begin
      state_next  = IDLE;
      region_next = '0;
      addr_next   = '0;
      cnt_next    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next  = LOAD;
            region_next = '0;
            addr_next   = '0;
          end
        end
        LOAD: begin
          if (beat) begin
            sel_next = region + 3'd1;
            if (addr == ADDR_LAST) begin
              addr_next = '0;
              if (region == LAST_REGION) begin
                region_next = '0;
                state_next  = RUN;
                cnt_next    = CNT_W'(run_cycles);
              end else begin
                region_next = region + 3'd1;
              end
            end else begin
              addr_next = addr + 1'b1;
            end
          end
        end
        RUN: begin
          // Enable is registered, so the window starts one cycle after entering RUN
          // and the zero-count cycle produces done with the enable released.
          if (cnt == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            en_n_next = 1'b0;
            cnt_next  = cnt - 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state               <= IDLE;
      region              <= '0;
      addr                <= '0;
      cnt                 <= '0;
      Data_in             <= '0;
      addr_inSRAM_offchip <= '0;
      SEL_SRAM_input      <= '0;
      EN_system_n         <= 1'b1;
      done                <= 1'b0;
    end else begin
      state          <= state_next;
      region         <= region_next;
      addr           <= addr_next;
      cnt            <= cnt_next;
      SEL_SRAM_input <= sel_next;
      EN_system_n    <= en_n_next;
      done           <= done_next;
      if (beat) begin
        Data_in             <= host.s_data;
        addr_inSRAM_offchip <= addr;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef LOAD_CHECKSUM_EN
  logic [bit_length-1:0] acc;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc <= '0;
    end else if (abort || (state == IDLE && start)) begin
      acc <= '0;
    end else if (beat) begin
      acc <= acc ^ host.s_data;
    end
  end

  assign checksum = acc;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_esn_load_sequencer.sv
// Directed self-checking bench for esn_load_sequencer with node_num=4, run_cycles=10.
module tb_esn_load_sequencer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic        abort;
  logic [31:0] Data_in;
  logic [9:0]  addr_inSRAM_offchip;
  logic [2:0]  SEL_SRAM_input;
  logic        EN_system_n;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ck_model = '0;

  esn_load_sequencer_if #(.bit_length(32)) host ();

  esn_load_sequencer #(
    .bit_length      (32),
    .addr_length_heap(10),
    .node_num        (4),
    .run_cycles      (10)
  ) dut (
    .clk                (clk),
    .nrst               (nrst),
    .start              (start),
    .abort              (abort),
    .host               (host),
    .Data_in            (Data_in),
    .addr_inSRAM_offchip(addr_inSRAM_offchip),
    .SEL_SRAM_input     (SEL_SRAM_input),
    .EN_system_n        (EN_system_n),
    .busy               (busy),
    .done               (done),
    .checksum           (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ck_exp();
`ifdef LOAD_CHECKSUM_EN
    return ck_model;
`else
    return 32'h0;
`endif
  endfunction

  // Called at a negedge in IDLE; returns at the negedge where LOAD is visible.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    ck_model = '0;
    check("start_ready", host.s_ready, 1);
    check("start_busy", busy, 1);
    check("start_ck", checksum, ck_exp());
  endtask

  task automatic do_load(input bit toggle, input int abort_beat, input logic [31:0] base);
    int          beat = 0;
    int          wr = 0;
    bit          pend = 0;
    bit          aborted = 0;
    bit          fin = 0;
    logic [31:0] ed = '0;
    logic [2:0]  es = '0;
    logic [9:0]  ea = '0;
    for (int c = 0; c < 100 && !fin; c++) begin
      if (pend) begin
        check("wr_sel", SEL_SRAM_input, es);
        check("wr_addr", addr_inSRAM_offchip, ea);
        check("wr_data", Data_in, ed);
      end else begin
        check("nowr_sel", SEL_SRAM_input, 0);
      end
      pend = 0;
      if (aborted) begin
        check("abort_busy", busy, 0);
        check("abort_en", EN_system_n, 1);
        check("abort_done", done, 0);
        check("abort_ck", checksum, ck_exp());
        abort = 1'b0;
        host.s_valid = 1'b0;
        fin = 1;
      end else if (beat == 20) begin
        check("rdy_drop", host.s_ready, 0);
        host.s_valid = 1'b0;
        fin = 1;
      end else if (toggle && (c % 2 == 1)) begin
        host.s_valid = 1'b0;
      end else begin
        check("load_ready", host.s_ready, 1);
        host.s_valid = 1'b1;
        host.s_data  = base + 32'(beat);
        if (beat == abort_beat) begin
          abort    = 1'b1;
          aborted  = 1;
          ck_model = '0;
        end else begin
          pend = 1;
          es = 3'(wr / 4 + 1);
          ea = 10'(wr % 4);
          ed = base + 32'(beat);
          ck_model ^= ed;
          wr++;
        end
        beat++;
      end
      if (!fin) @(negedge clk);
    end
    check("load_timeout", fin, 1);
  endtask

  // Called at the negedge right after the last write is visible.
  task automatic run_window(input int start_at);
    int low = 0;
    int first_low = -1;
    int n_done = 0;
    int done_k = -1;
    check("pre_run_en", EN_system_n, 1);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (EN_system_n === 1'b0) begin
        low++;
        if (first_low < 0) first_low = k;
        check("run_sel", SEL_SRAM_input, 0);
      end
      if (done === 1'b1) begin
        n_done++;
        done_k = k;
        check("done_busy", busy, 0);
        check("done_en", EN_system_n, 1);
      end
      if (done_k > 0 && k == done_k + 1) begin
        check("done_pulse", done, 0);
        break;
      end
      if (k == start_at) start = 1'b1;
    end
    check("run_len", low, 10);
    check("run_first", first_low, 1);
    check("done_count", n_done, 1);
    check("run_ck", checksum, ck_exp());
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    host.s_valid = 1'b0;
    host.s_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", host.s_ready, 0);
    check("rst_data", Data_in, 0);
    check("rst_addr", addr_inSRAM_offchip, 0);
    check("rst_sel", SEL_SRAM_input, 0);
    check("rst_en", EN_system_n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ck", checksum, 0);
    nrst = 1'b1;

    // valid without start: nothing is accepted
    host.s_valid = 1'b1;
    host.s_data  = 32'hdead;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", host.s_ready, 0);
      check("idle_sel", SEL_SRAM_input, 0);
    end
    host.s_valid = 1'b0;

    // start and abort together: stay idle
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);

    // back-to-back load then run window
    do_start();
    do_load(0, -1, 32'h100);
    run_window(0);

    // toggled valid, start pulse inside the run window
    do_start();
    do_load(1, -1, 32'h1);
    check("ck_14", checksum, ck_exp());
    run_window(4);
    check("after_start_busy", busy, 0);

    // abort on the 7th beat, then restart cleanly
    do_start();
    do_load(0, 6, 32'h300);
    repeat (2) begin
      @(negedge clk);
      check("post_abort_done", done, 0);
      check("post_abort_busy", busy, 0);
    end
    do_start();
    do_load(0, -1, 32'h100);
    run_window(0);

    // asynchronous reset in the middle of a run window
    do_start();
    do_load(0, -1, 32'h500);
    repeat (3) @(negedge clk);
    check("mid_run_en", EN_system_n, 0);
    #2 nrst = 1'b0;
    #1;
    check("arst_en", EN_system_n, 1);
    check("arst_busy", busy, 0);
    check("arst_sel", SEL_SRAM_input, 0);
    check("arst_ck", checksum, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("arst_idle", host.s_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
